ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage sitting between the ID/EX pipeline buffer and the MEM stage. Consumes the
//  ID/EX outputs, computes the ALU result and the PC+imm value, keeps the Z/N condition
//  flags, resolves branches and register jumps, and registers everything into the EX/MEM
//  latch. Drives redirect/flush to IF/ID and stalls upstream during multi-cycle ops.
// PARAMETERS
//  XLEN     32  datapath width (PC, RS, RT, result)
//  MUL_LAT  32  multiply iterations (shift-add, one bit per cycle); used only with MUL_EN
// PORTS
//  clk           in   1     clock; all state updates on the falling edge (pipeline convention)
//  rst_n         in   1     synchronous active-low reset
//  valid_in      in   1     ID/EX holds a live instruction
//  pc_in         in   XLEN  PC of instruction
//  rs_in, rt_in  in   XLEN  operand A / operand B (RT is also store data)
//  wradr_in      in   6     destination register
//  aluop_in      in   4     0000 PASS_A, 0001 ADD, 0010 SUB(A-B), 0011 NEG(-A), 0100 INC(A+1), 0101 MUL, others PASS_A
//  imm_in        in   6     signed immediate for PC+imm (SVPC)
//  regwrite_in, memtoreg_in, pctoreg_in, memread_in, memwrite_in  in 1 each  control, forwarded
//  branchz_in, branchn_in, jump_in, jumpmem_in  in 1 each  control-flow flags
//  flush_in      in   1     squash from MEM (jumpMem resolution); highest non-reset priority
//  stall_out     out  1     hold IF/ID and ID/EX; do not present a new instruction
//  redirect      out  1     one-cycle pulse: fetch from redirect_pc
//  redirect_pc   out  XLEN  branch/jump target (= rs_in of the taken instruction)
//  valid_out, alu_out[XLEN], pcimm_out[XLEN], rt_out[XLEN], wradr_out[6], control outs  EX/MEM latch
//  flag_z, flag_n out 1     current condition flags
// BEHAVIOUR
//  - Reset (rst_n=0 at falling edge): all outputs 0, flags 0, FSM IDLE, squash window cleared.
//  - Latency 1: instruction accepted at edge k appears on EX/MEM outputs after edge k.
//  - alu_out per aluop, modulo 2^XLEN; pcimm_out = pc_in + sign_extend(imm_in).
//  - Flags updated only by accepted valid ops with regwrite=1, memtoreg=0, pctoreg=0:
//    Z = (result==0), N = result[XLEN-1]. Branches test flags BEFORE the current op's update.
//  - Taken: jump_in, or branchz_in&flag_z, or branchn_in&flag_n. Taken -> redirect=1 and
//    redirect_pc=rs_in for exactly one cycle after the edge; the next instruction presented
//    (wrong path) is squashed: forced valid_out=0, no flag update, no redirect.
//  - jumpmem_in is not resolved here; forwarded with rs_in as alu_out for MEM.
//  - valid_in=0 or squashed: valid_out=0, all control outs 0, data outs don't-care, flags held.
//  - flush_in=1: current input squashed, multiply aborted to IDLE, redirect suppressed.
//  - FSM: IDLE -> MUL on accepted MUL (MUL_EN only); MUL counts MUL_LAT iterations -> DONE;
//    DONE writes product low XLEN bits to EX/MEM with valid_out=1 -> IDLE.
//    stall_out=1 in MUL and DONE; valid_out=0 while in MUL (bubbles).
//  - Reset mid-multiply: IDLE, stall_out=0, partial product discarded.
//  - Reset > flush_in > multiply completion > new acceptance.
// CONFIGURATION
//  EX_MUL_EN defined: aluop 0101 = iterative unsigned multiply, stall as above.
//  EX_MUL_EN undefined: no multiplier/FSM logic; 0101 behaves as PASS_A, stall_out tied 0.
// TESTING
//  - ADD rs=5, rt=7, regwrite=1 -> next edge alu_out=12, valid_out=1, Z=0, N=0.
//  - SUB rs=3, rt=3 then branchz rs=0x40 -> Z=1, redirect=1 for one cycle, redirect_pc=0x40,
//    next instruction valid_out=0.
//  - NEG rs=1 -> alu_out=0xFFFFFFFF, N=1; INC rs=0xFFFFFFFF -> alu_out=0, Z=1 (wrap).
//  - SVPC pc=0x10, imm=6'b111110 -> pcimm_out=0x0E; flags unchanged.
//  - EX_MUL_EN: MUL 6x7 -> stall_out high 33 cycles, then alu_out=42, valid_out=1; repeat
//    with rst_n=0 at cycle 10 -> stall_out=0, no output; repeat with flush_in -> aborted.
//  - valid_in=0 for 3 cycles -> valid_out=0, flags held, redirect=0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX buffer and the MEM stage.
//
// Computes the ALU result and PC+imm, keeps the Z/N condition flags, resolves branches and
// register jumps, and registers everything into the EX/MEM latch. State updates on the
// falling clock edge; reset is synchronous and active low.
//
// Optional feature: define EX_MUL_EN to make aluop 0101 an iterative unsigned shift-add
// multiply (MUL_LAT iterations, stalling upstream). Without it, 0101 acts as PASS_A and
// stall_out is tied low.
//
// Ports:
//   clk, rst_n                  clock (falling-edge state), synchronous active-low reset
//   valid_in .. jumpmem_in      ID/EX outputs: PC, operands, destination, aluop, imm, controls
//   flush_in                    squash from MEM; overrides everything except reset
//   stall_out                   hold IF/ID and ID/EX while a multiply is in flight
//   redirect, redirect_pc       one-cycle fetch redirect to the taken target (rs_in)
//   valid_out .. jumpmem_out    EX/MEM latch (data, destination, forwarded controls)
//   flag_z, flag_n              current condition flags
module ex_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs_in,
    input  logic [XLEN-1:0] rt_in,
    input  logic [5:0]      wradr_in,
    input  logic [3:0]      aluop_in,
    input  logic [5:0]      imm_in,
    input  logic            regwrite_in,
    input  logic            memtoreg_in,
    input  logic            pctoreg_in,
    input  logic            memread_in,
    input  logic            memwrite_in,
    input  logic            branchz_in,
    input  logic            branchn_in,
    input  logic            jump_in,
    input  logic            jumpmem_in,
    input  logic            flush_in,
    output logic            stall_out,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            valid_out,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] pcimm_out,
    output logic [XLEN-1:0] rt_out,
    output logic [5:0]      wradr_out,
    output logic            regwrite_out,
    output logic            memtoreg_out,
    output logic            pctoreg_out,
    output logic            memread_out,
    output logic            memwrite_out,
    output logic            jumpmem_out,
    output logic            flag_z,
    output logic            flag_n
);

    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpNeg = 4'b0011;
    localparam logic [3:0] OpInc = 4'b0100;

    // Control bundle order: {jumpmem, memwrite, memread, pctoreg, memtoreg, regwrite}
    logic [5:0]      ctrl_in, ctrl_q;
    logic            valid_q, flag_z_q, flag_n_q, redirect_q, squash_q;
    logic [XLEN-1:0] alu_q, pcimm_q, rt_q, redirect_pc_q;
    logic [5:0]      wradr_q;

    logic [XLEN-1:0] alu_res, pcimm;
    logic            accept, taken, sets_flags;
    logic            mul_start, mul_busy, mul_done;
    logic [XLEN-1:0] mul_prod;
    logic [5:0]      mul_ctrl;

    assign ctrl_in    = {jumpmem_in, memwrite_in, memread_in, pctoreg_in, memtoreg_in,
                         regwrite_in};
    assign pcimm      = pc_in + {{(XLEN-6){imm_in[5]}}, imm_in};
    // The instruction right after a taken branch is wrong-path and is dropped.
    assign accept     = valid_in & ~squash_q & ~flush_in;
    // Branches see the flags as they were before this instruction.
    assign taken      = jump_in | (branchz_in & flag_z_q) | (branchn_in & flag_n_q);
    assign sets_flags = regwrite_in & ~memtoreg_in & ~pctoreg_in;

    always_comb begin
        case (aluop_in)
            OpAdd:   alu_res = rs_in + rt_in;
            OpSub:   alu_res = rs_in - rt_in;
            OpNeg:   alu_res = -rs_in;
            OpInc:   alu_res = rs_in + XLEN'(1);
            default: alu_res = rs_in;
        endcase
        // jumpMem target travels to MEM on the ALU bus.
        if (jumpmem_in) alu_res = rs_in;
    end

`ifdef EX_MUL_EN
    localparam logic [3:0]  OpMul   = 4'b0101;
    localparam int unsigned CntW    = $clog2(MUL_LAT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_LAT - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [XLEN-1:0] mul_a_q, mul_b_q, prod_q;
    logic [5:0]      mul_ctrl_q;

    assign stall_out = (state_q != StIdle);
    assign mul_busy  = (state_q == StMul);
    assign mul_done  = (state_q == StDone);
    assign mul_start = accept & ~stall_out & (aluop_in == OpMul) & ~jumpmem_in;
    assign mul_prod  = prod_q;
    assign mul_ctrl  = mul_ctrl_q;

    // Controls are captured at acceptance: ID/EX already holds the next instruction.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            prod_q     <= '0;
            mul_ctrl_q <= '0;
        end else if (flush_in) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mul_start) begin
                        state_q    <= StMul;
                        cnt_q      <= '0;
                        mul_a_q    <= rs_in;
                        mul_b_q    <= rt_in;
                        prod_q     <= '0;
                        mul_ctrl_q <= ctrl_in;
                    end
                end
                StMul: begin
                    if (mul_b_q[0]) prod_q <= prod_q + mul_a_q;
                    mul_a_q <= mul_a_q << 1;
                    mul_b_q <= mul_b_q >> 1;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) state_q <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end
`else
    assign stall_out = 1'b0;
    assign mul_busy  = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_start = 1'b0;
    assign mul_prod  = '0;
    assign mul_ctrl  = '0;
`endif

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            ctrl_q        <= '0;
            alu_q         <= '0;
            pcimm_q       <= '0;
            rt_q          <= '0;
            wradr_q       <= '0;
            flag_z_q      <= 1'b0;
            flag_n_q      <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            squash_q      <= 1'b0;
        end else begin
            redirect_q <= 1'b0;
            squash_q   <= 1'b0;
            if (flush_in) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end else if (mul_done) begin
                valid_q <= 1'b1;
                ctrl_q  <= mul_ctrl;
                alu_q   <= mul_prod;
                if (mul_ctrl[0] & ~mul_ctrl[1] & ~mul_ctrl[2]) begin
                    flag_z_q <= (mul_prod == '0);
                    flag_n_q <= mul_prod[XLEN-1];
                end
            end else if (mul_busy) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end else begin
                // A multiply start leaves a bubble; its data/destination stay latched here.
                valid_q <= accept & ~mul_start;
                ctrl_q  <= (accept & ~mul_start) ? ctrl_in : '0;
                alu_q   <= alu_res;
                pcimm_q <= pcimm;
                rt_q    <= rt_in;
                wradr_q <= wradr_in;
                if (accept & ~mul_start & sets_flags) begin
                    flag_z_q <= (alu_res == '0);
                    flag_n_q <= alu_res[XLEN-1];
                end
                if (accept & taken) begin
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= rs_in;
                    squash_q      <= 1'b1;
                end
            end
        end
    end

    assign redirect     = redirect_q;
    assign redirect_pc  = redirect_pc_q;
    assign valid_out    = valid_q;
    assign alu_out      = alu_q;
    assign pcimm_out    = pcimm_q;
    assign rt_out       = rt_q;
    assign wradr_out    = wradr_q;
    assign regwrite_out = ctrl_q[0];
    assign memtoreg_out = ctrl_q[1];
    assign pctoreg_out  = ctrl_q[2];
    assign memread_out  = ctrl_q[3];
    assign memwrite_out = ctrl_q[4];
    assign jumpmem_out  = ctrl_q[5];
    assign flag_z       = flag_z_q;
    assign flag_n       = flag_n_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage. Directed cases followed by random traffic,
// all compared against a behavioural reference model of the execute stage.
module tb_ex_stage;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned MulLat = 32;
`ifdef EX_MUL_EN
    localparam bit MulOn = 1'b1;
`else
    localparam bit MulOn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, valid_in, flush_in;
    logic [XLEN-1:0] pc_in, rs_in, rt_in;
    logic [5:0]      wradr_in, imm_in;
    logic [3:0]      aluop_in;
    logic regwrite_in, memtoreg_in, pctoreg_in, memread_in, memwrite_in;
    logic branchz_in, branchn_in, jump_in, jumpmem_in;
    logic            stall_out, redirect, valid_out, flag_z, flag_n;
    logic [XLEN-1:0] redirect_pc, alu_out, pcimm_out, rt_out;
    logic [5:0]      wradr_out;
    logic regwrite_out, memtoreg_out, pctoreg_out, memread_out, memwrite_out, jumpmem_out;

    ex_stage #(.XLEN(XLEN), .MUL_LAT(MulLat)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in), .rs_in(rs_in),
        .rt_in(rt_in), .wradr_in(wradr_in), .aluop_in(aluop_in), .imm_in(imm_in),
        .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in), .pctoreg_in(pctoreg_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in), .branchz_in(branchz_in),
        .branchn_in(branchn_in), .jump_in(jump_in), .jumpmem_in(jumpmem_in),
        .flush_in(flush_in), .stall_out(stall_out), .redirect(redirect),
        .redirect_pc(redirect_pc), .valid_out(valid_out), .alu_out(alu_out),
        .pcimm_out(pcimm_out), .rt_out(rt_out), .wradr_out(wradr_out),
        .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out), .pctoreg_out(pctoreg_out),
        .memread_out(memread_out), .memwrite_out(memwrite_out), .jumpmem_out(jumpmem_out),
        .flag_z(flag_z), .flag_n(flag_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic            m_valid, m_z, m_n, m_redirect, m_squash, m_mdone;
    logic [5:0]      m_ctrl, m_wradr, m_mctrl, m_mwradr;
    logic [XLEN-1:0] m_alu, m_pcimm, m_rt, m_rpc, m_prod;
    int              m_left = 0;  // edges until the pending product is written

    task automatic model_edge();
        logic [XLEN-1:0] res;
        logic [5:0]      ctrl;
        int              simm;
        ctrl = {jumpmem_in, memwrite_in, memread_in, pctoreg_in, memtoreg_in, regwrite_in};
        m_redirect = 1'b0;
        m_mdone    = 1'b0;
        if (!rst_n) begin
            m_valid = 0; m_ctrl = 0; m_alu = 0; m_pcimm = 0; m_rt = 0; m_wradr = 0;
            m_z = 0; m_n = 0; m_rpc = 0; m_squash = 0; m_left = 0;
            return;
        end
        if (flush_in) begin
            m_valid = 0; m_ctrl = 0; m_squash = 0; m_left = 0;
            return;
        end
        if (m_left > 0) begin
            m_left--;
            m_squash = 0;
            if (m_left == 0) begin
                m_valid = 1; m_ctrl = m_mctrl; m_alu = m_prod; m_wradr = m_mwradr; m_mdone = 1;
                if (m_mctrl[0] && !m_mctrl[1] && !m_mctrl[2]) begin
                    m_z = (m_prod == 0);
                    m_n = m_prod[XLEN-1];
                end
            end else begin
                m_valid = 0; m_ctrl = 0;
            end
            return;
        end
        if (!valid_in || m_squash) begin
            m_valid = 0; m_ctrl = 0; m_squash = 0;
            return;
        end
        m_squash = 0;
        if (jump_in || (branchz_in && m_z) || (branchn_in && m_n)) begin
            m_redirect = 1; m_rpc = rs_in; m_squash = 1;
        end
        simm    = $signed(imm_in);
        m_pcimm = pc_in + XLEN'(simm);
        m_rt    = rt_in;
        m_wradr = wradr_in;
        if (MulOn && aluop_in == 4'd5 && !jumpmem_in) begin
            m_prod  = rs_in * rt_in;
            m_mctrl = ctrl;
            m_mwradr = wradr_in;
            m_left  = MulLat + 1;
            m_valid = 0; m_ctrl = 0;
            return;
        end
        case (aluop_in)
            4'd1:    res = rs_in + rt_in;
            4'd2:    res = rs_in - rt_in;
            4'd3:    res = 0 - rs_in;
            4'd4:    res = rs_in + 1;
            default: res = rs_in;
        endcase
        if (jumpmem_in) res = rs_in;
        m_valid = 1; m_ctrl = ctrl; m_alu = res;
        if (regwrite_in && !memtoreg_in && !pctoreg_in) begin
            m_z = (res == 0);
            m_n = res[XLEN-1];
        end
    endtask

    task automatic compare();
        check_eq("valid_out", XLEN'(valid_out), XLEN'(m_valid));
        check_eq("ctrl_out", XLEN'({jumpmem_out, memwrite_out, memread_out, pctoreg_out,
                                    memtoreg_out, regwrite_out}), XLEN'(m_ctrl));
        check_eq("flag_z", XLEN'(flag_z), XLEN'(m_z));
        check_eq("flag_n", XLEN'(flag_n), XLEN'(m_n));
        check_eq("redirect", XLEN'(redirect), XLEN'(m_redirect));
        check_eq("stall_out", XLEN'(stall_out), XLEN'(m_left > 0));
        if (m_redirect) check_eq("redirect_pc", redirect_pc, m_rpc);
        if (m_valid) begin
            check_eq("alu_out", alu_out, m_alu);
            check_eq("wradr_out", XLEN'(wradr_out), XLEN'(m_wradr));
            if (!m_mdone) begin
                check_eq("pcimm_out", pcimm_out, m_pcimm);
                check_eq("rt_out", rt_out, m_rt);
            end
        end
    endtask

    // Inputs are set after a rising edge; the DUT samples them at the next falling edge.
    task automatic cycle();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        compare();
    endtask

    task automatic clear_inputs();
        valid_in = 0; pc_in = 0; rs_in = 0; rt_in = 0; wradr_in = 0; aluop_in = 0; imm_in = 0;
        regwrite_in = 0; memtoreg_in = 0; pctoreg_in = 0; memread_in = 0; memwrite_in = 0;
        branchz_in = 0; branchn_in = 0; jump_in = 0; jumpmem_in = 0; flush_in = 0;
    endtask

    task automatic present(input logic [3:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic rw);
        clear_inputs();
        valid_in = 1; aluop_in = op; rs_in = a; rt_in = b; regwrite_in = rw; wradr_in = 6'd3;
    endtask

    task automatic rand_inputs();
        if (m_left > 0) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            flush_in = ($urandom_range(0, 79) == 0);
            return;
        end
        rst_n       = ($urandom_range(0, 199) != 0);
        flush_in    = ($urandom_range(0, 29) == 0);
        valid_in    = m_squash ? 1'b1 : ($urandom_range(0, 3) != 0);
        aluop_in    = 4'($urandom_range(0, 15));
        if (aluop_in == 4'd5 && $urandom_range(0, 3) != 0) aluop_in = 4'd1;
        rt_in       = $urandom();
        case ($urandom_range(0, 3))
            0:       rs_in = rt_in;
            1:       rs_in = 0;
            2:       rs_in = 32'hFFFF_FFFF;
            default: rs_in = $urandom();
        endcase
        pc_in       = $urandom();
        imm_in      = 6'($urandom_range(0, 63));
        wradr_in    = 6'($urandom_range(0, 63));
        regwrite_in = ($urandom_range(0, 3) != 0);
        memtoreg_in = ($urandom_range(0, 7) == 0);
        pctoreg_in  = ($urandom_range(0, 7) == 0);
        memread_in  = ($urandom_range(0, 7) == 0);
        memwrite_in = ($urandom_range(0, 7) == 0);
        branchz_in  = ($urandom_range(0, 5) == 0);
        branchn_in  = ($urandom_range(0, 5) == 0);
        jump_in     = ($urandom_range(0, 9) == 0);
        jumpmem_in  = ($urandom_range(0, 9) == 0);
        if (aluop_in == 4'd5) begin
            branchz_in = 0; branchn_in = 0; jump_in = 0; jumpmem_in = 0;
        end
    endtask

    initial begin
        int n;
        clear_inputs();
        rst_n = 0;
        cycle();
        cycle();
        check_eq("rst_alu", alu_out, 0);
        check_eq("rst_pcimm", pcimm_out, 0);
        check_eq("rst_rt", rt_out, 0);
        check_eq("rst_wradr", XLEN'(wradr_out), 0);
        check_eq("rst_redirect_pc", redirect_pc, 0);
        rst_n = 1;

        present(4'd1, 5, 7, 1); cycle();
        check_eq("add_res", alu_out, 12);
        check_eq("add_valid", XLEN'(valid_out), 1);
        check_eq("add_z", XLEN'(flag_z), 0);
        check_eq("add_n", XLEN'(flag_n), 0);

        present(4'd2, 3, 3, 1); cycle();
        check_eq("sub_z", XLEN'(flag_z), 1);
        present(4'd0, 32'h40, 0, 0); branchz_in = 1; cycle();
        check_eq("bz_redirect", XLEN'(redirect), 1);
        check_eq("bz_target", redirect_pc, 32'h40);
        present(4'd1, 1, 1, 1); cycle();
        check_eq("squash_valid", XLEN'(valid_out), 0);
        check_eq("squash_redirect", XLEN'(redirect), 0);
        check_eq("squash_z_held", XLEN'(flag_z), 1);

        present(4'd3, 1, 0, 1); cycle();
        check_eq("neg_res", alu_out, 32'hFFFF_FFFF);
        check_eq("neg_n", XLEN'(flag_n), 1);
        present(4'd4, 32'hFFFF_FFFF, 0, 1); cycle();
        check_eq("inc_res", alu_out, 0);
        check_eq("inc_z", XLEN'(flag_z), 1);

        present(4'd0, 0, 0, 1); pctoreg_in = 1; pc_in = 32'h10; imm_in = 6'b111110; cycle();
        check_eq("svpc_pcimm", pcimm_out, 32'h0E);
        check_eq("svpc_z_held", XLEN'(flag_z), 1);

        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("idle_valid", XLEN'(valid_out), 0);
            check_eq("idle_z_held", XLEN'(flag_z), 1);
            check_eq("idle_redirect", XLEN'(redirect), 0);
        end

`ifdef EX_MUL_EN
        present(4'd5, 6, 7, 1); cycle();
        clear_inputs();
        n = 0;
        while (stall_out === 1'b1 && n < 60) begin
            n++;
            cycle();
        end
        check_eq("mul_stall_cycles", XLEN'(n), 33);
        check_eq("mul_res", alu_out, 42);
        check_eq("mul_valid", XLEN'(valid_out), 1);

        present(4'd5, 6, 7, 1); cycle();
        clear_inputs();
        for (int i = 0; i < 9; i++) cycle();
        rst_n = 0; cycle();
        check_eq("mul_rst_stall", XLEN'(stall_out), 0);
        check_eq("mul_rst_valid", XLEN'(valid_out), 0);
        rst_n = 1;
        for (int i = 0; i < 40; i++) cycle();

        present(4'd5, 6, 7, 1); cycle();
        clear_inputs();
        for (int i = 0; i < 5; i++) cycle();
        flush_in = 1; cycle();
        check_eq("mul_flush_stall", XLEN'(stall_out), 0);
        flush_in = 0;
        for (int i = 0; i < 40; i++) cycle();
`else
        present(4'd5, 9, 4, 1); cycle();
        check_eq("op5_pass_a", alu_out, 9);
        check_eq("op5_no_stall", XLEN'(stall_out), 0);
        n = 0;
`endif

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
